input_buffer_ctrl: RTL and testbench
====================================

INPUT_BUFFER_CTRL -- requirements
Module: input_buffer_ctrl

Interface
REQ-001 SHALL have parameter BEATS, default 8: number of 136-bit beats per 1088-bit block.
REQ-002 SHALL have parameter CNT_W, default 4: width of the beat counter and of blk_beats; must satisfy 2^CNT_W > BEATS.
REQ-003 SHALL have port scan_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port scan_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream beat available.
REQ-006 SHALL have port in_last, input, 1: the current beat is the final beat of the message; qualified by in_valid.
REQ-007 SHALL have port in_ready, output, 1: the controller accepts a beat this cycle.
REQ-008 SHALL have port shift_en, output, 1: shift strobe to the 1088-bit shift buffer.
REQ-009 SHALL have port pad_sel, output, 1: the buffer loads a pad beat instead of scan data.
REQ-010 SHALL have port pad_first, output, 1: the pad beat carries the domain byte 0x06 in its lowest byte.
REQ-011 SHALL have port pad_final, output, 1: the pad beat carries 0x80 in its highest byte.
REQ-012 SHALL have port blk_valid, output, 1: the buffer holds a complete block.
REQ-013 SHALL have port blk_ready, input, 1: the hash core consumes the block.
REQ-014 SHALL have port blk_last, output, 1: the presented block is the final block of the message.
REQ-015 SHALL have port blk_beats, output, CNT_W: number of data beats in the presented block.

Function
REQ-016 SHALL implement states IDLE, FILL, PAD and FULL; PAD exists only when the padding macro is defined.
REQ-017 SHALL drive in_ready=1 in IDLE and FILL and 0 in PAD and FULL.
REQ-018 SHALL make shift_en combinational: (in_valid & in_ready) in IDLE/FILL, 1 in every PAD cycle, 0 in FULL.
REQ-019 SHALL increment the beat counter on each shift_en and clear it on entry to IDLE.
REQ-020 SHALL transition IDLE->FILL on an accepted beat with in_last=0 when the count after the beat is below BEATS.
REQ-021 SHALL enter FULL on the beat that brings the count to BEATS; blk_valid rises the following cycle.
REQ-022 SHALL enter PAD or FULL, per REQ-034/REQ-035, on an accepted beat with in_last=1 and count after the beat below BEATS.
REQ-023 SHALL hold blk_valid, blk_last and blk_beats stable in FULL until blk_valid & blk_ready, then go to IDLE the next cycle.
REQ-024 SHALL let the block handshake complete in the same cycle blk_valid rises if blk_ready is already high; no beat is accepted in that cycle.
REQ-025 SHALL set blk_beats equal to the number of scan beats, excluding pad beats, shifted into the current block.
REQ-026 SHALL ignore in_last when in_valid=0.

Reset
REQ-027 SHALL, while scan_rst=1 at a clock edge, enter IDLE and clear the counter, blk_valid, blk_last and blk_beats.
REQ-028 SHALL hold in_ready=0, shift_en=0, pad_sel=0, pad_first=0 and pad_final=0 while scan_rst=1.
REQ-029 SHALL, on reset during FILL, PAD or FULL, discard the partial or pending block without further shifts.

Configuration
REQ-030 SHALL use macro INPUT_BUFFER_CTRL_PAD_EN to compile automatic SHA3 pad10*1 padding in or out.
REQ-031 SHALL, with the macro defined, assert pad_sel in PAD and shift pad beats until count=BEATS, then enter FULL with blk_last=1.
REQ-032 SHALL, with the macro defined, assert pad_first on the first PAD beat and pad_final on the last PAD beat; both are set when a single beat is padded.
REQ-033 SHALL, with the macro defined, treat in_last on beat BEATS as a non-final full block with blk_last=0 and, after the handshake, shift BEATS pad beats to form a final pad-only block (blk_beats=0, blk_last=1).
REQ-034 SHALL, with the macro defined, route in_last with count after the beat below BEATS to PAD.
REQ-035 SHALL, with the macro undefined, route in_last directly to FULL with blk_last=1 and blk_beats equal to the beats received, and tie pad_sel, pad_first and pad_final to 0.

Verification
REQ-036 SHALL cover: 8 back-to-back beats, in_last=0, blk_ready=1 -> 8 shift_en pulses, blk_valid for 1 cycle, blk_beats=8, blk_last=0.
REQ-037 SHALL cover, macro defined: 5 beats with in_last on beat 5 -> 3 pad shifts, pad_first on pad beat 1, pad_final on pad beat 3, blk_beats=5, blk_last=1.
REQ-038 SHALL cover, macro defined: 7 beats with in_last on beat 7 -> 1 pad shift with pad_first=pad_final=1, then blk_valid.
REQ-039 SHALL cover, macro defined: 8 beats with in_last on beat 8 -> block 1 with blk_last=0, then 8 pad shifts and block 2 with blk_beats=0, blk_last=1.
REQ-040 SHALL cover: blk_ready held low 10 cycles in FULL with in_valid=1 -> in_ready=0, no shift_en, outputs stable.
REQ-041 SHALL cover: scan_rst pulsed after 4 beats -> IDLE next cycle with counter 0; the next block requires 8 fresh beats.

Source files
------------

// File: rtl/input_buffer_ctrl.sv
// Input buffer controller: collects 136-bit scan beats into 1088-bit blocks
// and hands complete blocks to the hash core with a valid/ready handshake.
// Optional SHA3 pad10*1 padding is compiled in with INPUT_BUFFER_CTRL_PAD_EN.
module input_buffer_ctrl #(
  parameter int BEATS = 8,
  parameter int CNT_W = 4
) (
  input  logic             scan_clk,
  input  logic             scan_rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             shift_en,
  output logic             pad_sel,
  output logic             pad_first,
  output logic             pad_final,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_last,
  output logic [CNT_W-1:0] blk_beats
);

`ifdef INPUT_BUFFER_CTRL_PAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PAD = 2'd2, FULL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd3} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  // dcnt counts only scan beats; cnt counts every shift, pad beats included
  logic [CNT_W-1:0] dcnt, dcnt_nxt, dcnt_inc;
  logic             blk_valid_nxt, blk_last_nxt;
  logic [CNT_W-1:0] blk_beats_nxt;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
  // a message ending exactly on a block boundary still owes a pad-only block
  logic             pend, pend_nxt;
`endif

  assign cnt_inc  = cnt + 1'b1;
  assign dcnt_inc = dcnt + 1'b1;

  // Next-state, counter and handshake decode; strobes forced low in reset
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dcnt_nxt      = dcnt;
    blk_valid_nxt = blk_valid;
    blk_last_nxt  = blk_last;
    blk_beats_nxt = blk_beats;
    in_ready      = 1'b0;
    shift_en      = 1'b0;
    pad_sel       = 1'b0;
    pad_first     = 1'b0;
    pad_final     = 1'b0;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
    pend_nxt      = pend;
`endif
    case (state)
      IDLE, FILL: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        if (in_valid) begin
          cnt_nxt  = cnt_inc;
          dcnt_nxt = dcnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_nxt     = FULL;
            blk_valid_nxt = 1'b1;
            blk_beats_nxt = dcnt_inc;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
            blk_last_nxt  = 1'b0;
            pend_nxt      = in_last;
`else
            blk_last_nxt  = in_last;
`endif
          end else if (in_last) begin
`ifdef INPUT_BUFFER_CTRL_PAD_EN
            state_nxt     = PAD;
`else
            state_nxt     = FULL;
            blk_valid_nxt = 1'b1;
            blk_last_nxt  = 1'b1;
            blk_beats_nxt = dcnt_inc;
`endif
          end else begin
            state_nxt = FILL;
          end
        end
      end
`ifdef INPUT_BUFFER_CTRL_PAD_EN
      PAD: begin
        pad_sel   = 1'b1;
        shift_en  = 1'b1;
        pad_first = (cnt == dcnt);
        pad_final = (cnt_inc == LAST_CNT);
        cnt_nxt   = cnt_inc;
        if (cnt_inc == LAST_CNT) begin
          state_nxt     = FULL;
          blk_valid_nxt = 1'b1;
          blk_last_nxt  = 1'b1;
          blk_beats_nxt = dcnt;
        end
      end
`endif
      FULL: begin
        if (blk_valid && blk_ready) begin
          blk_valid_nxt = 1'b0;
          cnt_nxt       = '0;
          dcnt_nxt      = '0;
          state_nxt     = IDLE;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
          if (pend) begin
            state_nxt = PAD;
            pend_nxt  = 1'b0;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (scan_rst) begin
      in_ready  = 1'b0;
      shift_en  = 1'b0;
      pad_sel   = 1'b0;
      pad_first = 1'b0;
      pad_final = 1'b0;
    end
  end

  // State, counters and block descriptor registers
  always_ff @(posedge scan_clk) begin
    if (scan_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_beats <= '0;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
      pend      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dcnt      <= dcnt_nxt;
      blk_valid <= blk_valid_nxt;
      blk_last  <= blk_last_nxt;
      blk_beats <= blk_beats_nxt;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
      pend      <= pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Testbench for input_buffer_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a block-queue reference model.
module tb_input_buffer_ctrl;
  localparam int BEATS = 8;
  localparam int CNT_W = 4;
`ifdef INPUT_BUFFER_CTRL_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic             in_ready, shift_en, pad_sel, pad_first, pad_final;
  logic             blk_valid, blk_last;
  logic [CNT_W-1:0] blk_beats;

  input_buffer_ctrl #(.BEATS(BEATS), .CNT_W(CNT_W)) dut (
    .scan_clk(clk), .scan_rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .shift_en(shift_en), .pad_sel(pad_sel),
    .pad_first(pad_first), .pad_final(pad_final), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_last(blk_last), .blk_beats(blk_beats)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, want, $time);
    end
  endtask

  // Reference model: a queue of expected blocks plus pad/presentation bookkeeping
  typedef struct { int beats; bit last; } blk_t;
  blk_t m_q[$];
  bit   m_full = 0, m_known = 0;
  int   m_k = 0, m_pad_left = 0, m_pad_total = 0;

  // Observation counters used by directed scenarios
  int n_shift = 0, n_bv = 0, n_pad = 0, n_pf = 0, n_pfin = 0;
  int last_bb = -1, last_bl = -1;
  bit last_acc = 0;

  task automatic tick();
    bit er, es, ep;
    @(negedge clk);
    ep = !rst && (m_pad_left > 0);
    er = !rst && !m_full && (m_pad_left == 0);
    es = ep ? 1'b1 : (er && in_valid);
    chk("in_ready", in_ready, er);
    chk("shift_en", shift_en, es);
    chk("pad_sel", pad_sel, ep);
    chk("pad_first", pad_first, ep && (m_pad_left == m_pad_total));
    chk("pad_final", pad_final, ep && (m_pad_left == 1));
    if (!rst && m_known) begin
      chk("blk_valid", blk_valid, m_full);
      if (m_full && m_q.size() > 0) begin
        chk("blk_beats", blk_beats, m_q[0].beats);
        chk("blk_last", blk_last, m_q[0].last);
      end
    end
    if (shift_en === 1'b1) n_shift++;
    if (shift_en === 1'b1 && pad_sel === 1'b1) n_pad++;
    if (pad_first === 1'b1) n_pf++;
    if (pad_final === 1'b1) n_pfin++;
    if (blk_valid === 1'b1 && !rst) begin
      n_bv++;
      last_bb = int'(blk_beats);
      last_bl = int'(blk_last);
    end
    last_acc = in_valid && er;
    // advance the model to the state after the coming clock edge
    if (rst) begin
      m_q.delete();
      m_full = 0; m_k = 0; m_pad_left = 0; m_pad_total = 0; m_known = 1;
    end else if (m_full) begin
      if (blk_ready) begin
        void'(m_q.pop_front());
        m_full = 0;
        if (m_q.size() > 0) begin
          m_pad_left = BEATS; m_pad_total = BEATS;
        end
      end
    end else if (m_pad_left > 0) begin
      m_pad_left--;
      if (m_pad_left == 0) m_full = 1;
    end else if (in_valid) begin
      m_k++;
      if (m_k == BEATS) begin
        m_q.push_back('{beats: BEATS, last: PAD ? 1'b0 : in_last});
        if (PAD && in_last) m_q.push_back('{beats: 0, last: 1'b1});
        m_full = 1; m_k = 0;
      end else if (in_last) begin
        m_q.push_back('{beats: m_k, last: 1'b1});
        if (PAD) begin
          m_pad_left = BEATS - m_k; m_pad_total = BEATS - m_k;
        end else m_full = 1;
        m_k = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit last);
    int t;
    in_valid = 1'b1;
    in_last  = last;
    t = 0;
    do begin
      tick();
      t++;
    end while (!last_acc && t < 100);
    if (!last_acc) chk("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Send one message of n beats (in_last on the final one if req) then idle
  task automatic run_msg(input int n, input bit with_last, input int idle);
    for (int i = 1; i <= n; i++) send_beat(with_last && (i == n));
    repeat (idle) tick();
  endtask

  int b_sh, b_bv, b_pad, b_pf, b_pfin;
  task automatic snap();
    b_sh = n_shift; b_bv = n_bv; b_pad = n_pad; b_pf = n_pf; b_pfin = n_pfin;
  endtask

  initial begin
    do_reset();
    chk("reset_blk_valid", blk_valid, 0);
    chk("reset_blk_beats", blk_beats, 0);
    chk("reset_blk_last", blk_last, 0);

    // full block, no last, core always ready
    blk_ready = 1'b1;
    snap();
    run_msg(8, 1'b0, 3);
    chk("full8_shifts", n_shift - b_sh, 8);
    chk("full8_bv_cycles", n_bv - b_bv, 1);
    chk("full8_beats", last_bb, 8);
    chk("full8_last", last_bl, 0);

    // short message with last on beat 5
    snap();
    run_msg(5, 1'b1, 12);
    chk("msg5_beats", last_bb, 5);
    chk("msg5_last", last_bl, 1);
`ifdef INPUT_BUFFER_CTRL_PAD_EN
    chk("msg5_pads", n_pad - b_pad, 3);
    chk("msg5_pad_first", n_pf - b_pf, 1);
    chk("msg5_pad_final", n_pfin - b_pfin, 1);

    snap();
    run_msg(7, 1'b1, 12);
    chk("msg7_pads", n_pad - b_pad, 1);
    chk("msg7_pad_first", n_pf - b_pf, 1);
    chk("msg7_pad_final", n_pfin - b_pfin, 1);
    chk("msg7_bv_cycles", n_bv - b_bv, 1);

    snap();
    run_msg(8, 1'b1, 20);
    chk("msg8_pads", n_pad - b_pad, 8);
    chk("msg8_blocks", n_bv - b_bv, 2);
    chk("msg8_pad_beats", last_bb, 0);
    chk("msg8_pad_last", last_bl, 1);
`else
    chk("msg5_pads", n_pad - b_pad, 0);
    snap();
    run_msg(8, 1'b1, 4);
    chk("msg8_blocks", n_bv - b_bv, 1);
    chk("msg8_beats", last_bb, 8);
    chk("msg8_last", last_bl, 1);
`endif

    // back-pressure: core stalls 10 cycles while upstream keeps offering
    blk_ready = 1'b0;
    run_msg(8, 1'b0, 0);
    snap();
    in_valid = 1'b1;
    repeat (10) tick();
    chk("stall_shifts", n_shift - b_sh, 0);
    chk("stall_bv_cycles", n_bv - b_bv, 10);
    chk("stall_beats", last_bb, 8);
    in_valid = 1'b0;
    blk_ready = 1'b1;
    repeat (3) tick();

    // reset after 4 beats: the next block needs 8 fresh beats
    run_msg(4, 1'b0, 0);
    do_reset();
    snap();
    run_msg(7, 1'b0, 3);
    chk("rst_no_block", n_bv - b_bv, 0);
    run_msg(1, 1'b0, 3);
    chk("rst_block_after8", n_bv - b_bv, 1);
    chk("rst_block_beats", last_bb, 8);

    // randomized traffic, occasional resets, in_last toggling with in_valid low
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 4) == 0);
      blk_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b1;
    repeat (25) tick();
    chk("drain_no_block", blk_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
